// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared constants and helpers for the tournament branch predictor.
// Metadata layout, MSB to LSB: {lidx, gidx, ghr_snap, local_pr, global_pr}.
package hybrid_branch_predictor_pkg;

    localparam logic [2:0] NZP_ALWAYS = 3'b111;
    localparam logic [2:0] NZP_NEVER  = 3'b000;

    localparam int unsigned META_LOCAL_BIT  = 1;
    localparam int unsigned META_GLOBAL_BIT = 0;
    localparam int unsigned META_SNAP_LSB   = 2;

    function automatic int unsigned meta_width(input int unsigned lidx_w,
                                               input int unsigned ghist_w);
        return lidx_w + 2 * ghist_w + 2;
    endfunction

endpackage

// File: rtl/hybrid_branch_predictor_sat_counter_table.sv
// Flop-array table of saturating counters: one combinational direction read,
// one read-modify-write training port that steps the stored value up or down.
module sat_counter_table #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             upd_en,
    input  logic             upd_inc,
    input  logic [IDX_W-1:0] upd_idx
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    logic [CTR_W-1:0] ctrs [DEPTH];
    logic [CTR_W-1:0] cur;
    logic [CTR_W-1:0] nxt;

    assign rd_msb = ctrs[rd_idx][CTR_W-1];
    assign cur    = ctrs[upd_idx];

    always_comb begin
        nxt = cur;
        if (upd_inc && cur != '1) begin
            nxt = cur + 1'b1;
        end else if (!upd_inc && cur != '0) begin
            nxt = cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrs[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            ctrs[upd_idx] <= nxt;
        end
    end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// Tournament (local / gshare / chooser) branch predictor with its own GHR,
// condition-code override, metadata tag for training, and perf counters.
module hybrid_branch_predictor
    import hybrid_branch_predictor_pkg::*;
#(
    parameter int unsigned LIDX_W  = 8,
    parameter int unsigned GHIST_W = 6,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned PERF_W  = 16,
    localparam int unsigned META_W = LIDX_W + 2 * GHIST_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [15:0]       pred_pc,
    input  logic [2:0]        nzp,
    input  logic              cc_valid,
    input  logic [2:0]        cc,
    output logic              pred_taken,
    output logic [META_W-1:0] pred_meta,
    input  logic              upd_valid,
    input  logic [META_W-1:0] upd_meta,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);
    logic [GHIST_W-1:0] ghr;
    logic [LIDX_W-1:0]  lidx;
    logic [GHIST_W-1:0] gidx;
    logic               local_pr;
    logic               global_pr;
    logic               choose_global;
    logic               table_pr;
    logic               unused_pc_bits;

    logic [LIDX_W-1:0]  upd_lidx;
    logic [GHIST_W-1:0] upd_gidx;
    logic [GHIST_W-1:0] upd_snap;
    logic               upd_local_pr;
    logic               upd_global_pr;
    logic               cho_en;

    assign lidx           = pred_pc[LIDX_W:1];
    assign gidx           = pred_pc[GHIST_W:1] ^ ghr;
    assign unused_pc_bits = ^{pred_pc[15:LIDX_W+1], pred_pc[0]};

    assign upd_lidx      = upd_meta[META_W-1 -: LIDX_W];
    assign upd_gidx      = upd_meta[META_SNAP_LSB+2*GHIST_W-1 -: GHIST_W];
    assign upd_snap      = upd_meta[META_SNAP_LSB+GHIST_W-1 -: GHIST_W];
    assign upd_local_pr  = upd_meta[META_LOCAL_BIT];
    assign upd_global_pr = upd_meta[META_GLOBAL_BIT];
    assign cho_en        = upd_valid && (upd_local_pr != upd_global_pr);

    sat_counter_table #(.IDX_W(LIDX_W), .CTR_W(CTR_W)) u_local (
        .clk(clk), .rst_n(rst_n), .rd_idx(lidx), .rd_msb(local_pr),
        .upd_en(upd_valid), .upd_inc(upd_taken), .upd_idx(upd_lidx)
    );

    sat_counter_table #(.IDX_W(GHIST_W), .CTR_W(CTR_W)) u_gshare (
        .clk(clk), .rst_n(rst_n), .rd_idx(gidx), .rd_msb(global_pr),
        .upd_en(upd_valid), .upd_inc(upd_taken), .upd_idx(upd_gidx)
    );

    sat_counter_table #(.IDX_W(LIDX_W), .CTR_W(CTR_W)) u_chooser (
        .clk(clk), .rst_n(rst_n), .rd_idx(lidx), .rd_msb(choose_global),
        .upd_en(cho_en), .upd_inc(upd_global_pr == upd_taken), .upd_idx(upd_lidx)
    );

    assign table_pr  = choose_global ? global_pr : local_pr;
    // Meta always records raw table outputs so training is independent of overrides.
    assign pred_meta = {lidx, gidx, ghr, local_pr, global_pr};

    always_comb begin
        pred_taken = table_pr;
        if (nzp == NZP_ALWAYS) begin
            pred_taken = 1'b1;
        end else if (nzp == NZP_NEVER) begin
            pred_taken = 1'b0;
        end else if (cc_valid) begin
            pred_taken = |(nzp & cc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispredict) begin
            ghr <= {upd_snap[GHIST_W-2:0], upd_taken};
        end else if (pred_valid) begin
            ghr <= {ghr[GHIST_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (upd_valid) begin
            if (perf_branches != '1) perf_branches <= perf_branches + 1'b1;
            if (upd_mispredict && perf_mispred != '1) perf_mispred <= perf_mispred + 1'b1;
        end
    end

endmodule
